msk_key_streamer: RTL and testbench



---
 rtl/msk_key_streamer_pkg.sv | 42 ++++
 rtl/msk_key_streamer_counter.sv | 42 ++++
 rtl/msk_key_streamer.sv | 146 ++++++++++++++
 tb/tb_msk_key_streamer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_key_streamer_pkg.sv
// msk_key_streamer shared definitions: key size codes,
// words-per-share constants and FSM state encoding.
package msk_key_streamer_pkg;

    localparam logic [1:0] KSIZE_128 = 2'b00;
    localparam logic [1:0] KSIZE_192 = 2'b01;
    localparam logic [1:0] KSIZE_256 = 2'b10;

    localparam int WPS_128 = 4;
    localparam int WPS_192 = 6;
    localparam int WPS_256 = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_CHECK,
        S_SEND
    } state_t;

    // Unknown codes fall back to 128-bit so a bad code still yields a valid key.
    function automatic logic [1:0] norm_ksize(input logic [1:0] ks);
        logic [1:0] r;
        unique case (ks)
            KSIZE_192: r = KSIZE_192;
            KSIZE_256: r = KSIZE_256;
            default:   r = KSIZE_128;
        endcase
        return r;
    endfunction

    // Index of the last word within one share.
    function automatic logic [2:0] word_bound(input logic [1:0] ks);
        logic [2:0] r;
        unique case (ks)
            KSIZE_192: r = 3'(WPS_192 - 1);
            KSIZE_256: r = 3'(WPS_256 - 1);
            default:   r = 3'(WPS_128 - 1);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/msk_key_streamer_counter.sv
// Serial (share, word) index counter for the key streamer.
// Word wraps at the bound and then advances the share.
module msk_key_streamer_counter #(
    parameter int D     = 2,
    parameter int NBITS = 3,
    parameter int SW    = (D > 1) ? $clog2(D) : 1
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic [NBITS-1:0] i_bound,
    output logic [SW-1:0]    o_share,
    output logic [NBITS-1:0] o_word,
    output logic             o_last
);

    logic [SW-1:0]    r_share;
    logic [NBITS-1:0] r_word;
    logic             w_wrap;

    assign w_wrap  = (r_word == i_bound);
    assign o_last  = w_wrap && (r_share == SW'(D - 1));
    assign o_share = r_share;
    assign o_word  = r_word;

    // Advance word index, carrying into the share index at the bound.
    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            r_share <= '0;
            r_word  <= '0;
        end else if (i_inc) begin
            if (w_wrap) begin
                r_word  <= '0;
                r_share <= o_last ? '0 : r_share + 1'b1;
            end else begin
                r_word <= r_word + 1'b1;
            end
        end
    end

endmodule

// File: rtl/msk_key_streamer.sv
// Streams a d-share key into the masked key holder, word by word.
// Optional: MSK_KEY_STREAMER_CLEAR_EN clears the key buffer after use.
module msk_key_streamer
    import msk_key_streamer_pkg::*;
#(
    parameter int d = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [256*d-1:0] key_in,
    input  logic [1:0]       key_size_in,
    input  logic             mode_inverse_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             start_fetch_procedure,
    output logic [1:0]       key_size_cfg,
    output logic             mode_inverse,
    output logic [31:0]      data_out,
    output logic             data_out_valid,
    input  logic             data_out_ready,
    input  logic             holder_busy,
    output logic             busy,
    output logic             done
);

    localparam int SW = (d > 1) ? $clog2(d) : 1;
    localparam int IW = SW + 3;

    state_t             r_state;
    state_t             w_next;
    logic [256*d-1:0]   r_key;
    logic [1:0]         r_ksize;
    logic               r_mode;
    logic               r_done;
    logic               w_load;
    logic               w_hs;
    logic               w_last;
    logic [SW-1:0]      w_share;
    logic [2:0]         w_word;
    logic [IW-1:0]      w_sel;
    logic [31:0]        w_data;

    assign w_load = (r_state == S_IDLE) && load_valid && !rst;
    assign w_hs   = (r_state == S_SEND) && data_out_ready;
    assign w_sel  = {w_share, w_word};

    msk_key_streamer_counter #(
        .D     (d),
        .NBITS (3),
        .SW    (SW)
    ) u_cnt (
        .clk     (clk),
        .i_rst   (rst),
        .i_clear (w_load),
        .i_inc   (w_hs),
        .i_bound (word_bound(r_ksize)),
        .o_share (w_share),
        .o_word  (w_word),
        .o_last  (w_last)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic and handshake-facing outputs.
    always_comb begin
        w_next                = r_state;
        load_ready            = 1'b0;
        start_fetch_procedure = 1'b0;
        data_out_valid        = 1'b0;
        busy                  = !rst && (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                load_ready = !rst;
                if (load_valid) w_next = S_START;
            end
            S_START: begin
                if (!holder_busy) begin
                    start_fetch_procedure = !rst;
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next = data_out_ready ? S_SEND : S_START;
            end
            S_SEND: begin
                data_out_valid = !rst;
                if (data_out_ready && w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Configuration captured at load, held until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ksize <= KSIZE_128;
            r_mode  <= 1'b0;
        end else if (w_load) begin
            r_ksize <= norm_ksize(key_size_in);
            r_mode  <= mode_inverse_in;
        end
    end

    // One-cycle done pulse registered off the last handshake.
    always_ff @(posedge clk) begin
        if (rst) r_done <= 1'b0;
        else     r_done <= w_hs && w_last;
    end

`ifdef MSK_KEY_STREAMER_CLEAR_EN
    // Key buffer wiped on reset and right after the last word leaves.
    always_ff @(posedge clk) begin
        if (rst)                r_key <= '0;
        else if (w_load)        r_key <= key_in;
        else if (w_hs && w_last) r_key <= '0;
    end
`else
    // Key buffer keeps the last key; no reset needed on data storage.
    always_ff @(posedge clk) begin
        if (w_load) r_key <= key_in;
    end
`endif

    // d*8:1 word select on the captured buffer.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < d * 8; i++) begin
            if (w_sel == IW'(i)) w_data = r_key[32*i +: 32];
        end
    end

`ifdef MSK_KEY_STREAMER_CLEAR_EN
    assign data_out = data_out_valid ? w_data : 32'd0;
`else
    assign data_out = rst ? 32'd0 : w_data;
`endif

    assign key_size_cfg = rst ? 2'b00 : r_ksize;
    assign mode_inverse = !rst && r_mode;
    assign done         = !rst && r_done;

endmodule

// File: tb/tb_msk_key_streamer.sv
// Directed bench for msk_key_streamer (d=2 and d=3 instances).
// Holder side is modelled inline; expected words come from the key.
module tb_msk_key_streamer;
    import msk_key_streamer_pkg::*;

    logic         clk;
    logic         rst;
    logic         holder_busy;
    logic         data_out_ready;
    logic         lv2;
    logic         lv3;
    logic         mode_in;
    logic [1:0]   ks_in;
    logic [767:0] key_all;
    bit           sel;

    logic        lr2, st2, mi2, dv2, b2, dn2;
    logic [1:0]  kc2;
    logic [31:0] do2;
    logic        lr3, st3, mi3, dv3, b3, dn3;
    logic [1:0]  kc3;
    logic [31:0] do3;

    int n_cmp = 0;
    int n_bad = 0;

    msk_key_streamer #(.d(2)) u_d2 (
        .clk                   (clk),
        .rst                   (rst),
        .key_in                (key_all[511:0]),
        .key_size_in           (ks_in),
        .mode_inverse_in       (mode_in),
        .load_valid            (lv2),
        .load_ready            (lr2),
        .start_fetch_procedure (st2),
        .key_size_cfg          (kc2),
        .mode_inverse          (mi2),
        .data_out              (do2),
        .data_out_valid        (dv2),
        .data_out_ready        (data_out_ready),
        .holder_busy           (holder_busy),
        .busy                  (b2),
        .done                  (dn2)
    );

    msk_key_streamer #(.d(3)) u_d3 (
        .clk                   (clk),
        .rst                   (rst),
        .key_in                (key_all),
        .key_size_in           (ks_in),
        .mode_inverse_in       (mode_in),
        .load_valid            (lv3),
        .load_ready            (lr3),
        .start_fetch_procedure (st3),
        .key_size_cfg          (kc3),
        .mode_inverse          (mi3),
        .data_out              (do3),
        .data_out_valid        (dv3),
        .data_out_ready        (data_out_ready),
        .holder_busy           (holder_busy),
        .busy                  (b3),
        .done                  (dn3)
    );

    logic        w_lr, w_start, w_mi, w_valid, w_busy, w_done;
    logic [1:0]  w_kc;
    logic [31:0] w_data;

    assign w_lr    = sel ? lr3 : lr2;
    assign w_start = sel ? st3 : st2;
    assign w_mi    = sel ? mi3 : mi2;
    assign w_valid = sel ? dv3 : dv2;
    assign w_busy  = sel ? b3  : b2;
    assign w_done  = sel ? dn3 : dn2;
    assign w_kc    = sel ? kc3 : kc2;
    assign w_data  = sel ? do3 : do2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [767:0] rnd_key();
        logic [767:0] k;
        for (int i = 0; i < 24; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // At a negedge in IDLE: present one load, end in START.
    task automatic load(input bit s, input logic [767:0] k,
                        input logic [1:0] ks, input logic m);
        sel     = s;
        key_all = k;
        ks_in   = ks;
        mode_in = m;
        if (s) lv3 = 1'b1;
        else   lv2 = 1'b1;
        chk("ld_ready", w_lr, 1);
        @(negedge clk);
        lv2 = 1'b0;
        lv3 = 1'b0;
        chk("ld_busy", w_busy, 1);
        chk("ld_ready_off", w_lr, 0);
        key_all = ~k;
    endtask

    // In START with holder_busy low: expect pulse, end in CHECK.
    task automatic go(input logic rdy);
        #1;
        chk("start", w_start, 1);
        data_out_ready = rdy;
        @(negedge clk);
        chk("start_once", w_start, 0);
        chk("check_novalid", w_valid, 0);
    endtask

    // From CHECK: consume n_stop words and compare each.
    task automatic stream(input logic [767:0] k, input int wps,
                          input int dd, input int n_stop,
                          input bit stall, output logic [31:0] lastw);
        int          kk = 0;
        int          cyc = 0;
        int          s;
        int          t;
        int          total = dd * wps;
        bit          pend = 0;
        logic [31:0] held = '0;
        logic [31:0] ew;
        lastw = '0;
        @(negedge clk);
        while (kk < n_stop && cyc < 3000) begin
            s  = kk / wps;
            t  = kk % wps;
            ew = k[256*s + 32*t +: 32];
            chk("valid", w_valid, 1);
            chk("no_done", w_done, 0);
            chk("word", w_data, ew);
            if (pend) chk("stable", w_data, held);
            held = w_data;
            data_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (data_out_ready) begin
                kk++;
                lastw = w_data;
                pend  = 0;
            end else begin
                pend = 1;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) chk("timeout", 64'(kk), 64'(n_stop));
        if (n_stop == total) begin
            chk("done", w_done, 1);
            chk("idle_busy", w_busy, 0);
            chk("idle_valid", w_valid, 0);
            chk("idle_ready", w_lr, 1);
            data_out_ready = 1'b0;
            @(negedge clk);
            chk("done_once", w_done, 0);
            chk("busy_after", w_busy, 0);
        end
    endtask

    initial begin
        logic [767:0] k;
        logic [31:0]  lw;
        rst            = 1'b1;
        holder_busy    = 1'b0;
        data_out_ready = 1'b0;
        lv2            = 1'b0;
        lv3            = 1'b0;
        mode_in        = 1'b0;
        ks_in          = 2'b00;
        key_all        = '0;
        sel            = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", lr2, 0);
        chk("rst_busy", b2, 0);
        chk("rst_valid", dv2, 0);
        chk("rst_start", st2, 0);
        chk("rst_data", do2, 0);
        chk("rst_done", dn2, 0);
        chk("rst_kcfg", kc2, 0);
        chk("rst_mode", mi2, 0);
        chk("rst_ready3", lr3, 0);
        chk("rst_data3", do3, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", lr2, 1);
        chk("post_rst_ready3", lr3, 1);
        @(negedge clk);

        // d=2, 128-bit, recognisable words
        k = rnd_key();
        for (int t = 0; t < 4; t++) begin
            k[32*t +: 32]       = 32'h0001_0000 + 32'(t);
            k[256 + 32*t +: 32] = 32'h0002_0000 + 32'(t);
        end
        load(0, k, KSIZE_128, 1'b0);
        go(1'b1);
        chk("a_kcfg", w_kc, KSIZE_128);
        stream(k, 4, 2, 8, 0, lw);
        chk("a_last", lw, 32'h0002_0003);

        // d=3, 256-bit, inverse direction
        k = rnd_key();
        load(1, k, KSIZE_256, 1'b1);
        go(1'b1);
        chk("b_kcfg", w_kc, KSIZE_256);
        chk("b_mode", w_mi, 1);
        stream(k, 8, 3, 24, 0, lw);
        chk("b_last", lw, k[256*2 + 224 +: 32]);
        chk("b_kcfg_hold", w_kc, KSIZE_256);

        // d=2, 192-bit, random ready stalls
        k = rnd_key();
        load(0, k, KSIZE_192, 1'b0);
        go(1'b1);
        chk("c_kcfg", w_kc, KSIZE_192);
        chk("c_mode", w_mi, 0);
        stream(k, 6, 2, 12, 1, lw);

        // d=3, holder busy for 10 cycles, stray loads ignored
        k = rnd_key();
        holder_busy = 1'b1;
        load(1, k, KSIZE_128, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("d_no_start", w_start, 0);
            chk("d_busy", w_busy, 1);
            lv3 = 1'b1;
            @(negedge clk);
        end
        lv3 = 1'b0;
        holder_busy = 1'b0;
        go(1'b1);
        stream(k, 4, 3, 12, 0, lw);

        // d=3, 192-bit, holder takes a refresh at CHECK
        k = rnd_key();
        load(1, k, KSIZE_192, 1'b0);
        go(1'b0);
        holder_busy = 1'b1;
        @(negedge clk);
        chk("e_back_start", w_start, 0);
        chk("e_busy", w_busy, 1);
        chk("e_novalid", w_valid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("e_wait", w_start, 0);
        end
        holder_busy = 1'b0;
        go(1'b1);
        stream(k, 6, 3, 18, 0, lw);

        // d=2, reserved size code falls back to 128-bit
        k = rnd_key();
        load(0, k, 2'b11, 1'b0);
        go(1'b1);
        chk("g_kcfg", w_kc, KSIZE_128);
        stream(k, 4, 2, 8, 0, lw);

        // d=3, reset after 3 transfers
        k = rnd_key();
        load(1, k, KSIZE_256, 1'b0);
        go(1'b1);
        stream(k, 8, 3, 3, 0, lw);
        data_out_ready = 1'b0;
        chk("f_mid_valid", w_valid, 1);
        chk("f_mid_word", w_data, k[96 +: 32]);
        rst = 1'b1;
        @(negedge clk);
        chk("f_rst_valid", w_valid, 0);
        chk("f_rst_busy", w_busy, 0);
        chk("f_rst_ready", w_lr, 0);
        chk("f_rst_data", w_data, 0);
        rst = 1'b0;
        #1;
        chk("f_idle_ready", w_lr, 1);
        chk("f_idle_valid", w_valid, 0);
        chk("f_idle_busy", w_busy, 0);
`ifdef MSK_KEY_STREAMER_CLEAR_EN
        chk("f_idle_data", w_data, 0);
`endif
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
